// File: rtl/div_sequencer_if.sv
// Request/result bundle between the divide sequencer, its requester/consumer
// and the combinational divider it wraps.
interface div_sequencer_if;
    logic        start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_z;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    modport slave (
        input  start, operand_a, operand_b, div_z, out_ready,
        output div_a, div_b, busy, out_valid, hi, lo, dbz
    );

    modport master (
        output start, operand_a, operand_b, div_z, out_ready,
        input  div_a, div_b, busy, out_valid, hi, lo, dbz
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle sequencer and sign fixup around the magnitude-only combinational
// divider; delivers signed HI (remainder) / LO (quotient) over valid/ready.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; busy low
//   S_SETTLE | magnitudes held on div_a/div_b while the divider settles
//   S_FIXUP  | one cycle: apply signs, or substitute dbz/overflow result
//   S_HOLD   | result presented with out_valid until out_ready
module div_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           clr,
    div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_FIXUP  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0]  CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_dbz_case;
    logic        r_ovf_case;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [63:0] r_z_cap;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dbz;
    logic        r_busy;
    logic        r_valid;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_is_dbz;
    logic        w_is_ovf;
    logic [31:0] w_neg_q;
    logic [31:0] w_neg_r;
    logic [31:0] w_dividend;

    // INT_MIN negates to itself, which is exactly the magnitude the divider wants.
    assign w_abs_a  = bus.operand_a[31] ? (32'd0 - bus.operand_a) : bus.operand_a;
    assign w_abs_b  = bus.operand_b[31] ? (32'd0 - bus.operand_b) : bus.operand_b;
    assign w_is_dbz = (bus.operand_b == 32'd0);
    assign w_is_ovf = (bus.operand_a == INT_MIN) && (bus.operand_b == 32'hFFFF_FFFF);

    assign w_neg_q    = 32'd0 - r_z_cap[31:0];
    assign w_neg_r    = 32'd0 - r_z_cap[63:32];
    // Original dividend is rebuilt from magnitude and sign rather than stored twice.
    assign w_dividend = r_sign_a ? (32'd0 - r_div_a) : r_div_a;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dbz_case <= 1'b0;
            r_ovf_case <= 1'b0;
            r_div_a    <= '0;
            r_div_b    <= '0;
            r_z_cap    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dbz      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign_a   <= bus.operand_a[31];
                        r_sign_b   <= bus.operand_b[31];
                        r_div_a    <= w_abs_a;
                        r_div_b    <= w_abs_b;
                        r_cnt      <= CNT_LOAD;
                        r_busy     <= 1'b1;
                        r_dbz_case <= w_is_dbz;
                        r_ovf_case <= w_is_ovf;
                        r_state    <= (w_is_dbz || w_is_ovf) ? S_FIXUP : S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_z_cap <= bus.div_z;
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_FIXUP: begin
                    if (r_dbz_case) begin
                        r_lo  <= 32'hFFFF_FFFF;
                        r_hi  <= w_dividend;
                        r_dbz <= 1'b1;
                    end else if (r_ovf_case) begin
                        r_lo  <= INT_MIN;
                        r_hi  <= 32'd0;
                        r_dbz <= 1'b0;
                    end else begin
                        r_lo  <= (r_sign_a ^ r_sign_b) ? w_neg_q : r_z_cap[31:0];
                        r_hi  <= r_sign_a ? w_neg_r : r_z_cap[63:32];
                        r_dbz <= 1'b0;
                    end
                    r_valid <= 1'b1;
                    r_state <= S_HOLD;
                end

                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.div_a     = r_div_a;
    assign bus.div_b     = r_div_b;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_valid;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.dbz       = r_dbz;

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle control and sign-fixup stage wrapped around the team's combinational 32-bit divider.
- Registers the operands and drives them to the divider, then waits a programmable settle time for the long combinational path.
- Captures the divider's 64-bit {remainder, quotient} output and applies the signed correction, since the divider returns magnitudes only.
- Presents HI (remainder) and LO (quotient) to the HI/LO register writeback over a valid/ready handshake. Handles divide-by-zero and signed-overflow without using the divider.

Parameters:
- SETTLE_CYCLES, 4, cycles operands are held stable before div_z is sampled (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- operand_a  in  32  signed dividend, valid with start.
- operand_b  in  32  signed divisor, valid with start.
- div_a  out  32  registered |dividend| to divider input a.
- div_b  out  32  registered |divisor| to divider input b.
- div_z  in  64  divider output: [63:32] remainder magnitude, [31:0] quotient magnitude.
- busy  out  1  high from accepted start until handshake completes.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- hi  out  32  signed remainder.
- lo  out  32  signed quotient.
- dbz  out  1  divide-by-zero flag; valid with out_valid.

Behaviour:
- Reset (clr=1 at a rising edge), regardless of state:
  - State returns to IDLE.
  - div_a, div_b, hi, lo, settle counter, latched signs are cleared to 0.
  - busy, out_valid, dbz are cleared to 0.
  - An operation in progress is abandoned and produces no output.
- IDLE:
  - busy=0.
  - When start=1, on that edge: latch sign_a=operand_a[31] and sign_b=operand_b[31].
  - Drive div_a=|operand_a| and div_b=|operand_b|, using two's complement negate; 0x80000000 stays 0x80000000.
  - Load counter=SETTLE_CYCLES-1 and set busy=1.
  - Next state:
    - FIXUP if operand_b==0 (dbz case).
    - FIXUP if operand_a==0x80000000 and operand_b==0xFFFFFFFF (overflow case).
    - SETTLE otherwise.
- SETTLE:
  - Counter decrements each cycle; div_a and div_b are held constant.
  - When the counter reaches 0, div_z is registered into z_cap on that edge and the state moves to FIXUP.
  - Total cycles spent in SETTLE = SETTLE_CYCLES.
- FIXUP (exactly 1 cycle). The following are registered at the exiting edge:
  - Normal case: lo = (sign_a^sign_b) ? -z_cap[31:0] : z_cap[31:0]; hi = sign_a ? -z_cap[63:32] : z_cap[63:32]; dbz=0.
  - dbz case: lo=0xFFFFFFFF, hi=original dividend, dbz=1.
  - Overflow case: lo=0x80000000, hi=0, dbz=0.
  - Then set out_valid=1 and move to HOLD.
- HOLD:
  - out_valid=1; hi, lo and dbz are stable.
  - On an edge with out_ready=1: out_valid←0, busy←0, state→IDLE.
  - hi, lo and dbz keep their values until the next FIXUP or reset.
- Latency, start accepted at edge N:
  - Normal case: out_valid is high after edge N+SETTLE_CYCLES+1.
  - dbz/overflow case: out_valid is high after edge N+1.
- Handshake and start rules:
  - start while busy=1 is ignored and must not be queued.
  - out_ready in any state other than HOLD is ignored.
  - Back-to-back operation: start may be accepted on the first edge where state is IDLE, i.e. the edge after the handshake. Minimum issue interval = SETTLE_CYCLES+3 cycles.
- Arithmetic: all negation is 32-bit two's complement, wrapping. The remainder sign follows the dividend and the quotient truncates toward zero.

Test Plan:
- 100 / 7, SETTLE_CYCLES=4, out_ready held 1 → out_valid 5 cycles after start edge; lo=0x0000000E, hi=0x00000002, dbz=0; busy low the cycle after.
- -100 / 7 and 100 / -7 → lo=0xFFFFFFF2 in both cases; hi=0xFFFFFFFE for the first and hi=0x00000002 for the second.
- 5 / 0 → out_valid one cycle after start, div_z ignored; lo=0xFFFFFFFF, hi=0x00000005, dbz=1. Then 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulsing start meanwhile → hi, lo, out_valid stable; the extra start is not accepted. Raising out_ready completes exactly one handshake, with busy=0 the next cycle.
- Reset mid-SETTLE: assert clr 2 cycles into SETTLE → next cycle all outputs 0 and state IDLE. A new 9 / 3 then yields lo=3, hi=0 at nominal latency.
- Settle sampling: a bench divider model holds div_z at garbage until SETTLE_CYCLES cycles after div_a/div_b change → the result must still be correct, proving sampling happens only on the final settle edge.
